// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and backing-memory fill rule for the
// direct-mapped read-only cache.
package cache_pkg;

  localparam int LINE_SIZE       = 32;
  localparam int NUM_LINES       = 8;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int MEM_LATENCY     = 4;

  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = LINE_SIZE - OFFSET_W - INDEX_W;
  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);

  localparam logic [LINE_SIZE-1:0] MEM_FILL = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  function automatic logic [LINE_SIZE-1:0] mem_word(input logic [LINE_SIZE-1:0] a);
    return a ^ MEM_FILL;
  endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// Backing memory model: returns the whole block containing req_addr.
// Contents are a pure function of the address, so there is no storage.
module cache_backing_mem
  import cache_pkg::*;
(
  input  logic [LINE_SIZE-1:0]                       req_addr,
  output logic [WORDS_PER_BLOCK-1:0][LINE_SIZE-1:0]  block
);

  always_comb begin
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      block[w] = mem_word({req_addr[LINE_SIZE-1:OFFSET_W], OFFSET_W'(w)});
    end
  end

endmodule

// File: rtl/cache.sv
// Direct-mapped read-only cache: combinational hit path, fixed-latency
// refill of a whole block from the embedded backing memory on a miss.
module cache
  import cache_pkg::*;
(
  output logic                 busywait,
  output logic [LINE_SIZE-1:0] data,
  input  logic                 reset,
  input  logic                 clk,
  input  logic [LINE_SIZE-1:0] address
);

  // Handshake: the requester holds address; data is valid in any cycle
  // where busywait is low and reset is low.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_SIZE-1:0]   req_addr_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [WORDS_PER_BLOCK-1:0][LINE_SIZE-1:0] data_q [NUM_LINES];

  logic [OFFSET_W-1:0]    offset;
  logic [INDEX_W-1:0]     index;
  logic [TAG_W-1:0]       tag;
  logic [INDEX_W-1:0]     req_index;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   latch_req;
  logic                   fill;
  logic [WORDS_PER_BLOCK-1:0][LINE_SIZE-1:0] fill_block;

  assign offset    = address[OFFSET_W-1:0];
  assign index     = address[OFFSET_W +: INDEX_W];
  assign tag       = address[LINE_SIZE-1 -: TAG_W];
  assign req_index = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_tag   = req_addr_q[LINE_SIZE-1 -: TAG_W];

  // An unknown address resolves to a miss rather than an X hit.
  assign hit = ((valid_q[index] && (tag_q[index] == tag)) === 1'b1);

  cache_backing_mem u_mem (
    .req_addr (req_addr_q),
    .block    (fill_block)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busywait  = 1'b0;
    data      = '0;
    latch_req = 1'b0;
    fill      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          data = data_q[index][offset];
        end else begin
          busywait  = 1'b1;
          latch_req = 1'b1;
          cnt_d     = '0;
          state_d   = MEM_READ;
        end
      end
      MEM_READ: begin
        busywait = 1'b1;
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        busywait = 1'b1;
        fill     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      busywait  = 1'b0;
      data      = '0;
      latch_req = 1'b0;
      fill      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill) valid_q[req_index] <= 1'b1;
    end
  end

  // Line storage needs no reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (latch_req) req_addr_q <= address;
    if (fill) begin
      tag_q[req_index]  <= req_tag;
      data_q[req_index] <= fill_block;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed scenarios plus random reads
// compared against a block-residency reference model.
module tb_cache;

  localparam int          LAT     = 4;
  localparam int          PENALTY = LAT + 2;
  localparam int          LINES   = 8;
  localparam logic [31:0] FILL    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        busywait;
  logic [31:0] data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  bit          m_valid [LINES];
  logic [31:0] m_blk   [LINES];

  cache dut (
    .busywait (busywait),
    .data     (data),
    .reset    (reset),
    .clk      (clk),
    .address  (address)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which block number lives in each line
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    logic [31:0] blk;
    blk = a >> 2;
    return m_valid[blk % LINES] && (m_blk[blk % LINES] == blk);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    logic [31:0] blk;
    blk = a >> 2;
    m_valid[blk % LINES] = 1'b1;
    m_blk[blk % LINES]   = blk;
  endtask

  // Drivers
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'b0, busywait}, 32'd1);
      check({tag, "_data0"}, data, 32'd0);
      next_cycle();
    end
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] a);
    exp_q.push_back(a ^ FILL);
    @(negedge clk);
    check({tag, "_busy"}, {31'b0, busywait}, 32'd0);
    check({tag, "_data"}, data, exp_q.pop_front());
    next_cycle();
  endtask

  task automatic expect_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, {31'b0, busywait}, 32'd0);
    check({tag, "_data"}, data, 32'd0);
    next_cycle();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    address = a;
    if (!model_hit(a)) begin
      expect_busy({tag, "_miss"}, PENALTY);
      model_fill(a);
    end
    expect_hit(tag, a);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    expect_reset_outputs("pulse_rst");
    reset = 1'b0;
    model_reset();
  endtask

  // Stimulus
  initial begin
    logic [31:0] a;
    reset   = 1'b1;
    address = 32'd0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      address = $urandom;
      expect_reset_outputs("init_rst");
    end
    reset = 1'b0;

    // First miss, then hits within the same block
    do_read("first", 32'd1);
    do_read("same_blk2", 32'd2);
    do_read("same_blk3", 32'd3);

    // Address moves during the refill; refill still uses the latched one
    pulse_reset();
    address = 32'd1;
    expect_busy("chg", 1);
    address = 32'd2;
    expect_busy("chg", PENALTY - 1);
    model_fill(32'd1);
    do_read("chg_after", 32'd2);

    // Eviction of index 0
    do_read("evict_new", 32'd33);
    do_read("evict_old", 32'd1);

    // Reset in the third MEM_READ cycle aborts the refill
    address = 32'd8;
    expect_busy("abort", 3);
    reset = 1'b1;
    expect_reset_outputs("abort_rst");
    reset = 1'b0;
    model_reset();
    do_read("abort_retry", 32'd8);

    // Held reset with arbitrary addresses, then every index cold
    do_read("warm", 32'd20);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      address = $urandom;
      expect_reset_outputs("held_rst");
    end
    reset = 1'b0;
    model_reset();
    for (int idx = 0; idx < LINES; idx++) begin
      a = ($urandom_range(0, 1000) << 5) | (idx << 2) | $urandom_range(0, 3);
      do_read("cold_idx", a);
    end

    // Random reads: small range for hits and evictions, some wide addresses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = $urandom_range(0, 127);
      do_read("rand", a);
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Read-only, direct-mapped, word-addressed instruction/data cache with an embedded fixed-latency backing memory model.
- A requester presents an address every cycle. The block either returns the word combinationally on a hit, or raises busywait while it refills the block from backing memory.
- Self-contained: no external memory port.

Parameters:
- line_size, 32, data word width and address width in bits.
- NUM_LINES, 8, number of cache lines (power of 2).
- WORDS_PER_BLOCK, 4, words per line (power of 2).
- MEM_LATENCY, 4, backing-memory read latency in cycles (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  line_size  word address of the current read request.
- busywait  output  1  high while the request cannot be served (miss or refill in progress).
- data  output  line_size  read data; valid only when busywait is low.
- Declaration order, fixed for positional instantiation: busywait, data, reset, clk, address.

Behaviour:
- Address split (defaults):
  - offset = address[1:0]
  - index = address[4:2]
  - tag = address[31:5]
  - General form: offset is log2(WORDS_PER_BLOCK) bits, index is log2(NUM_LINES) bits, tag is the remainder.
- Per line storage: valid bit, tag, and WORDS_PER_BLOCK x line_size data.
- Backing memory contents: word at address A = A ^ 32'hDEAD_BEEF. Combinational function, no storage array.
- hit = valid[index] && tag_store[index]==tag, evaluated combinationally every cycle.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - On hit: busywait=0 and data=selected word, same cycle (zero latency).
    - On miss: busywait=1 combinationally; latch address into req_addr; next state MEM_READ with cnt=0.
  - MEM_READ: busywait=1; cnt increments each cycle; after MEM_LATENCY cycles go to UPDATE.
  - UPDATE: busywait=1. At the edge leaving UPDATE, write all words of the block at req_addr (block-aligned), set the tag, set valid=1, then go to IDLE.
- Miss penalty: busywait is high for exactly MEM_LATENCY+2 cycles (6 by default). The next IDLE cycle hits.
- Refill uses the latched req_addr. Address changes during busywait do not corrupt the refill; the requester is still required to hold the address. After return to IDLE, the current address is looked up again.
- data = 0 whenever busywait is high or reset is high.
- Reset:
  - While reset=1: busywait=0 and data=0, overriding hit/miss.
  - At the clock edge: all valid bits cleared, state returns to IDLE, cnt=0.
  - Reset during MEM_READ/UPDATE aborts the refill with no partial line write.
- Unknown or X address while not in reset is treated as a miss (no X propagation into valid bits).
- Consecutive addresses in the same block cost one miss only.
- Eviction: a miss to an occupied index with a different tag overwrites that line. There is no write-back.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, MEM_READ, UPDATE}
  - derived widths OFFSET_W, INDEX_W, TAG_W
  - memory fill constant 32'hDEAD_BEEF
- Sub-module cache_backing_mem: req_addr in, block of words out. It contains the fill function only; the latency counter lives in the cache FSM.

Test Plan:
- Reset then address=1: busywait=1 immediately, for 6 cycles; next cycle busywait=0 and data=32'hDEAD_BEEE.
- After that refill, address=2: hit same cycle, busywait=0, data=32'hDEAD_BEED; address=3 gives data=32'hDEAD_BEEC.
- address=1, then changed to 2 one cycle into the miss: refill completes after 6 cycles; then address=2 hits with data=32'hDEAD_BEED and no second miss.
- address=1 refilled, then address=33 (same index 0, tag 1): miss, 6 busy cycles, data=32'h DEAD_BECE; then address=1 misses again (evicted).
- address=8 (index 2) miss; assert reset in the 3rd MEM_READ cycle: busywait=0 and data=0 during reset; after reset address=8 misses again with a full 6-cycle penalty.
- reset=1 held with any address: busywait=0 and data=0; after release, every index misses on first access.
